// File: rtl/seq_ctrl_unit.sv
// Sequencing controller for the multiply datapath: button synchronisers and edge
// detectors, wrapping page index, operand-load handshake and multiply watchdog.
module seq_ctrl_unit #(
   parameter int NUM_OPERANDS   = 4,
   parameter int IDX_W          = 2,
   parameter int NUM_PAGES      = 8,
   parameter int PAGE_W         = 3,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              btn_center,
   input  logic              btn_left,
   input  logic              btn_right,
   input  logic              start_mult,
   input  logic              load_ack,
   input  logic              mult_done,
   output logic              scroll_left,
   output logic              scroll_right,
   output logic [PAGE_W-1:0] page,
   output logic              load_req,
   output logic [IDX_W-1:0]  load_idx,
   output logic              mult_start,
   output logic              mult_active,
   output logic              done,
   output logic              timeout_err,
   output logic [2:0]        state_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      LOAD   = 3'b001,
      MSTART = 3'b010,
      MULT   = 3'b011,
      DONE   = 3'b100,
      ERR    = 3'b101
   } state_t;

   state_t state, state_next;

   // Button order within the packed vectors: [0] centre, [1] left, [2] right.
   logic [2:0][SYNC_STAGES-1:0] sync;
   logic [2:0]                  hist;
   logic [2:0]                  raw;
   logic [2:0]                  last;
   logic [2:0]                  pulse;
   logic                        start;
   logic                        page_en;

   logic [IDX_W-1:0]  idx, idx_next;
   logic [TO_W-1:0]   cnt, cnt_next;
   logic [PAGE_W-1:0] page_q, page_next;

   assign raw = {btn_right, btn_left, btn_center};

   always_comb begin
      last = '0;
      for (int unsigned b = 0; b < 3; b++) begin
         last[b] = sync[b][SYNC_STAGES-1];
      end
   end

   assign pulse = last & ~hist;
   assign start = pulse[0] | start_mult;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         hist <= '0;
      end else if (clr) begin
         sync <= '0;
         hist <= '0;
      end else begin
         for (int unsigned b = 0; b < 3; b++) begin
            sync[b] <= {sync[b][SYNC_STAGES-2:0], raw[b]};
         end
         hist <= last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         cnt    <= '0;
         page_q <= '0;
      end else if (clr) begin
         state  <= IDLE;
         idx    <= '0;
         cnt    <= '0;
         page_q <= '0;
      end else begin
         state  <= state_next;
         idx    <= idx_next;
         cnt    <= cnt_next;
         page_q <= page_next;
      end
   end

   always_comb begin
      state_next  = state;
      idx_next    = idx;
      cnt_next    = cnt;
      load_req    = 1'b0;
      mult_start  = 1'b0;
      mult_active = 1'b0;
      done        = 1'b0;
      timeout_err = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
               idx_next   = '0;
            end
         end
         LOAD: begin
            load_req = 1'b1;
            if (load_ack) begin
               if (idx == IDX_W'(NUM_OPERANDS - 1)) begin
                  state_next = MSTART;
                  idx_next   = '0;
               end else begin
                  idx_next = idx + IDX_W'(1);
               end
            end
         end
         MSTART: begin
            mult_start = 1'b1;
            state_next = MULT;
            cnt_next   = '0;
         end
         MULT: begin
            mult_active = 1'b1;
            cnt_next    = cnt + TO_W'(1);
            // Completion takes precedence over a watchdog expiry in the same cycle.
            if (mult_done) begin
               state_next = DONE;
            end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               state_next = ERR;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_next = LOAD;
               idx_next   = '0;
            end
         end
         ERR: begin
            timeout_err = 1'b1;
            if (start) begin
               state_next = LOAD;
               idx_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   always_comb begin
      page_en   = (state == IDLE) || (state == DONE) || (state == ERR);
      page_next = page_q;
      if (page_en && pulse[2] && !pulse[1]) begin
         page_next = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
      end else if (page_en && pulse[1] && !pulse[2]) begin
         page_next = (page_q == '0) ? PAGE_W'(NUM_PAGES - 1) : page_q - PAGE_W'(1);
      end
   end

   assign scroll_left  = pulse[1];
   assign scroll_right = pulse[2];
   assign page         = page_q;
   assign load_idx     = idx;
   assign state_o      = state;

endmodule

// File: doc/seq_ctrl_unit.md
Name: seq_ctrl_unit

Overview:
Parametrised sequencing controller for the multiply datapath. It synchronises and edge-detects the three user push buttons and maintains a wrapping scroll page index. It sequences a multi-word operand load with a per-word handshake, issues a one-cycle multiply start and guards the multiply phase with a timeout watchdog. It sits between the button/display front end and the multiplier/operand-register datapath.

Parameters:
NUM_OPERANDS, 4, number of operand words loaded per run (>=1)
IDX_W, 2, width of load_idx; 2**IDX_W >= NUM_OPERANDS
NUM_PAGES, 8, number of scroll positions (>=2)
PAGE_W, 3, width of page; 2**PAGE_W >= NUM_PAGES
SYNC_STAGES, 2, synchroniser flops per button (>=2)
TIMEOUT_CYCLES, 1024, maximum cycles allowed in MULT before error
TO_W, 10, timeout counter width; 2**TO_W >= TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clr  in  1  synchronous clear, active-high
btn_center  in  1  raw async button, start request
btn_left  in  1  raw async button, scroll left
btn_right  in  1  raw async button, scroll right
start_mult  in  1  synchronous start request from logic
load_ack  in  1  datapath accepted current operand word
mult_done  in  1  multiplier finished (level or pulse)
scroll_left  out  1  one-cycle left-button edge pulse
scroll_right  out  1  one-cycle right-button edge pulse
page  out  PAGE_W  current scroll page
load_req  out  1  requesting operand word load_idx
load_idx  out  IDX_W  index of operand word requested
mult_start  out  1  one-cycle multiplier start pulse
mult_active  out  1  high while in MULT
done  out  1  high while in DONE
timeout_err  out  1  high while in ERR
state_o  out  3  current state encoding

Behaviour:
- rst asynchronous: all flops 0, state IDLE, page 0. Every output is 0 during and after reset until a transition occurs.
- clr: synchronous, priority over all other inputs. Next edge: state IDLE, page 0, load_idx 0, timeout counter 0, synchronisers and edge-history flops cleared.
- Buttons: SYNC_STAGES-flop chain plus one history flop per button. Pulse = last_stage & ~history, combinational from registers. Pulse is exactly 1 cycle per press, regardless of hold length, and first appears SYNC_STAGES edges after the raw input is first sampled high.
- start = btn_center pulse OR start_mult.
- States (encoding): IDLE 000, LOAD 001, MSTART 010, MULT 011, DONE 100, ERR 101. Unused codes go to IDLE next cycle.
- IDLE: start -> LOAD.
- LOAD: load_req=1. load_idx starts at 0 on entry. Each load_ack increments load_idx. load_ack while load_idx==NUM_OPERANDS-1 -> MSTART, and load_idx returns to 0. start is ignored in LOAD.
- MSTART: mult_start=1 for exactly this cycle -> MULT unconditionally. Timeout counter cleared.
- MULT: mult_active=1 and the counter increments each cycle.
  - mult_done -> DONE.
  - Otherwise, when the counter == TIMEOUT_CYCLES-1 -> ERR.
  - mult_done and timeout in the same cycle: DONE wins.
  - start is ignored in MULT.
- DONE: done=1. start -> LOAD (new run); otherwise hold.
- ERR: timeout_err=1. start -> LOAD; otherwise hold. clr also exits.
- Page counter:
  - Updates only in IDLE, DONE or ERR; scroll pulses are still output in every state.
  - Right pulse: page+1, wrapping NUM_PAGES-1 -> 0.
  - Left pulse: page-1, wrapping 0 -> NUM_PAGES-1.
  - Left and right in the same cycle: no change.
- Latency: start seen at edge k -> load_req high after edge k. Final load_ack at edge j -> mult_start high in cycle j+1, mult_active high from cycle j+2.
- NUM_OPERANDS=1: a single ack goes to MSTART.

Test Plan:
- Reset: assert rst mid-MULT asynchronously -> all outputs 0, state_o=000 immediately, page=0.
- Button edge: hold btn_right high for 20 cycles -> scroll_right is a single 1-cycle pulse 2 cycles after first sample. page 7 -> 0 wrap. btn_left at page 0 -> page 7.
- Full run, NUM_OPERANDS=4: start_mult pulse; load_ack on 4 non-consecutive cycles -> load_idx steps 0,1,2,3. mult_start pulses once after the 4th ack; mult_done after 10 cycles -> done=1, state_o=100.
- Timeout, TIMEOUT_CYCLES=16: no mult_done -> timeout_err rises exactly 16 cycles after entering MULT. mult_done on cycle 16 instead -> DONE, no error.
- Ignored/simultaneous events: start during LOAD/MULT -> no effect. Left+right same cycle in IDLE -> page unchanged. Scroll in MULT -> pulses out, page unchanged.
- clr in LOAD with load_idx=2 -> next cycle IDLE, load_idx=0, load_req=0. A subsequent start restarts at index 0.
